// File: rtl/sim_jtag_sequencer.sv
// Command-driven JTAG bit-bang driver with buffered TDO capture responses.
// Optional build macro SIM_JTAG_SEQUENCER_TDO_CHECK_EN flags captures of undriven TDO.
//
// state  | meaning
// IDLE   | waiting for a command
// TCK_LO | TCK low phase of a CLOCK command, TMS/TDI already updated
// TCK_HI | TCK high phase; TDO sampled on entry
// TRST   | TRSTn asserted for the requested cycle count
// WAIT   | pins held for the requested cycle count
// DONE   | EXIT seen; no further commands until reset
module sim_jtag_sequencer #(
  parameter int          TCK_DIV   = 2,
  parameter int          N_CHAINS  = 1,
  parameter int          RSP_DEPTH = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             enable,
  input  logic                                             init_done,
  input  logic                                             cmd_valid,
  output logic                                             cmd_ready,
  input  logic [1:0]                                       cmd_op,
  input  logic                                             cmd_tms,
  input  logic                                             cmd_tdi,
  input  logic                                             cmd_capture,
  input  logic [((N_CHAINS > 1) ? $clog2(N_CHAINS) : 1)-1:0] cmd_chain,
  input  logic [31:0]                                      cmd_data,
  output logic                                             rsp_valid,
  input  logic                                             rsp_ready,
  output logic                                             rsp_tdo,
  output logic                                             jtag_TCK,
  output logic                                             jtag_TMS,
  output logic                                             jtag_TDI,
  output logic                                             jtag_TRSTn,
  input  logic [N_CHAINS-1:0]                              jtag_TDO_data,
  input  logic [N_CHAINS-1:0]                              jtag_TDO_driven,
  output logic [31:0]                                      exit
);

  localparam int              CW       = (N_CHAINS > 1) ? $clog2(N_CHAINS) : 1;
  localparam int              NX       = 1 << CW;
  localparam int              PW       = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int              NW       = $clog2(RSP_DEPTH + 1);
  localparam logic [31:0]     DIV_M1   = 32'(TCK_DIV - 1);
  localparam logic [PW-1:0]   PTR_LAST = PW'(RSP_DEPTH - 1);
  localparam logic [NW-1:0]   DEPTH_N  = NW'(RSP_DEPTH);

  localparam logic [1:0] OP_CLOCK = 2'd0;
  localparam logic [1:0] OP_TRST  = 2'd1;
  localparam logic [1:0] OP_WAIT  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_TCK_LO, S_TCK_HI, S_TRST, S_WAIT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            tck_q, tck_d;
  logic            tms_q, tms_d;
  logic            tdi_q, tdi_d;
  logic            trstn_q, trstn_d;
  logic [31:0]     exit_q, exit_d;
  logic [15:0]     lfsr_q, lfsr_d, lfsr_nxt;
  logic            capture_q, capture_d;
  logic [CW-1:0]   chain_q, chain_d;
  logic            rdy_q, rdy_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_tdo_q, rsp_tdo_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]   count_q, count_d;
  logic            mem [RSP_DEPTH];

  logic            accept, sample, push, pop;
  logic [NX-1:0]   drv_ext, dat_ext;
  logic            tdo_drv, tdo_sel;

`ifdef SIM_JTAG_SEQUENCER_TDO_CHECK_EN
  logic            err_q, err_d;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Chains beyond N_CHAINS read as undriven, so they fall back to the LFSR bit.
  always_comb begin
    drv_ext                 = '0;
    dat_ext                 = '0;
    drv_ext[N_CHAINS-1:0]   = jtag_TDO_driven;
    dat_ext[N_CHAINS-1:0]   = jtag_TDO_data;
    tdo_drv                 = drv_ext[chain_q];
    tdo_sel                 = tdo_drv ? dat_ext[chain_q] : lfsr_q[0];
    lfsr_nxt = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  assign cmd_ready = rdy_q & enable & init_done;
  assign accept    = cmd_valid & cmd_ready;
  assign sample    = (state_q == S_TCK_LO) && (cnt_q == 32'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tck_d     = tck_q;
    tms_d     = tms_q;
    tdi_d     = tdi_q;
    trstn_d   = trstn_q;
    exit_d    = exit_q;
    lfsr_d    = lfsr_q;
    capture_d = capture_q;
    chain_d   = chain_q;
    push      = 1'b0;
`ifdef SIM_JTAG_SEQUENCER_TDO_CHECK_EN
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_CLOCK: begin
              state_d   = S_TCK_LO;
              cnt_d     = DIV_M1;
              tck_d     = 1'b0;
              tms_d     = cmd_tms;
              tdi_d     = cmd_tdi;
              capture_d = cmd_capture;
              chain_d   = cmd_chain;
            end
            OP_TRST: begin
              state_d = S_TRST;
              trstn_d = 1'b0;
              cnt_d   = (cmd_data == 32'd0) ? 32'd0 : cmd_data - 32'd1;
            end
            OP_WAIT: begin
              if (cmd_data != 32'd0) begin
                state_d = S_WAIT;
                cnt_d   = cmd_data - 32'd1;
              end
            end
            default: begin
              state_d = S_DONE;
              exit_d  = {cmd_data[30:0], 1'b1};
            end
          endcase
        end
      end
      S_TCK_LO: begin
        if (sample) begin
          state_d = S_TCK_HI;
          cnt_d   = DIV_M1;
          tck_d   = 1'b1;
          lfsr_d  = lfsr_nxt;
          push    = capture_q;
`ifdef SIM_JTAG_SEQUENCER_TDO_CHECK_EN
          if (capture_q && !tdo_drv) begin
            err_d  = 1'b1;
            exit_d = 32'h3;
          end
`endif
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_TCK_HI: begin
        if (cnt_q == 32'd0) begin
          state_d = S_IDLE;
`ifdef SIM_JTAG_SEQUENCER_TDO_CHECK_EN
          if (err_q) state_d = S_DONE;
`endif
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_TRST: begin
        if (cnt_q == 32'd0) begin
          state_d = S_IDLE;
          trstn_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 32'd0) state_d = S_IDLE;
        else                cnt_d   = cnt_q - 32'd1;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // rsp_valid ignores this cycle's push so a response always shows one cycle later.
  always_comb begin
    pop         = rsp_valid_q & rsp_ready;
    count_d     = count_q + NW'(push) - NW'(pop);
    wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    rsp_valid_d = (count_q - NW'(pop)) != '0;
    rsp_tdo_d   = mem[rd_ptr_d];
    rdy_d       = (state_d == S_IDLE) && (count_d < DEPTH_N);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trstn_q     <= 1'b1;
      exit_q      <= '0;
      lfsr_q      <= LFSR_SEED;
      capture_q   <= 1'b0;
      chain_q     <= '0;
      rdy_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tdo_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      trstn_q     <= trstn_d;
      exit_q      <= exit_d;
      lfsr_q      <= lfsr_d;
      capture_q   <= capture_d;
      chain_q     <= chain_d;
      rdy_q       <= rdy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tdo_q   <= rsp_tdo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) mem[wr_ptr_q] <= tdo_sel;
  end

`ifdef SIM_JTAG_SEQUENCER_TDO_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  always_ff @(posedge clock) begin
    if (!reset && sample && capture_q && !tdo_drv)
      $error("sim_jtag_sequencer: captured undriven TDO on chain %0d", chain_q);
  end
`endif

  assign rsp_valid  = rsp_valid_q;
  assign rsp_tdo    = rsp_tdo_q;
  assign jtag_TCK   = tck_q;
  assign jtag_TMS   = tms_q;
  assign jtag_TDI   = tdi_q;
  assign jtag_TRSTn = trstn_q;
  assign exit       = exit_q;

endmodule

// File: tb/tb_sim_jtag_sequencer.sv
// Directed bench for sim_jtag_sequencer: capture vector table plus multi-cycle sequences.
module tb_sim_jtag_sequencer;

  localparam int TCK_DIV   = 2;
  localparam int N_CHAINS  = 4;
  localparam int RSP_DEPTH = 2;

  localparam logic [1:0] OP_CLOCK = 2'd0;
  localparam logic [1:0] OP_TRST  = 2'd1;
  localparam logic [1:0] OP_WAIT  = 2'd2;
  localparam logic [1:0] OP_EXIT  = 2'd3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        init_done = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic        cmd_tms = 1'b0;
  logic        cmd_tdi = 1'b0;
  logic        cmd_capture = 1'b0;
  logic [1:0]  cmd_chain = 2'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_tdo;
  logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
  logic [3:0]  jtag_TDO_data = 4'd0;
  logic [3:0]  jtag_TDO_driven = 4'd0;
  logic [31:0] exit;

  int n_checks = 0;
  int n_errors = 0;

  sim_jtag_sequencer #(
    .TCK_DIV   (TCK_DIV),
    .N_CHAINS  (N_CHAINS),
    .RSP_DEPTH (RSP_DEPTH),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .init_done       (init_done),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_tms         (cmd_tms),
    .cmd_tdi         (cmd_tdi),
    .cmd_capture     (cmd_capture),
    .cmd_chain       (cmd_chain),
    .cmd_data        (cmd_data),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_tdo         (rsp_tdo),
    .jtag_TCK        (jtag_TCK),
    .jtag_TMS        (jtag_TMS),
    .jtag_TDI        (jtag_TDI),
    .jtag_TRSTn      (jtag_TRSTn),
    .jtag_TDO_data   (jtag_TDO_data),
    .jtag_TDO_driven (jtag_TDO_driven),
    .exit            (exit)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] chain;
    logic [3:0] dat;
    logic [3:0] drv;
    logic       exp;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic tms, input logic tdi, input logic cap,
                      input logic [1:0] chain, input logic [31:0] data,
                      input logic [3:0] dat, input logic [3:0] drv);
    int i;
    i = 0;
    while (!cmd_ready && i < 100) begin
      tick();
      i++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
    jtag_TDO_data   = dat;
    jtag_TDO_driven = drv;
    cmd_op      = op;
    cmd_tms     = tms;
    cmd_tdi     = tdi;
    cmd_capture = cap;
    cmd_chain   = chain;
    cmd_data    = data;
    cmd_valid   = 1'b1;
    tick();
    cmd_valid   = 1'b0;
  endtask

  task automatic get_rsp(input string name, input logic exp);
    int i;
    i = 0;
    while (!rsp_valid && i < 100) begin
      tick();
      i++;
    end
    if (!rsp_valid) check({name, "_timeout"}, {31'd0, rsp_valid}, 32'd1);
    else            check(name, {31'd0, rsp_tdo}, {31'd0, exp});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    bit  seen;

    // Undriven entries expect the seed bits LSB first (0xACE1); driven ones expect the data bit.
    vecs[0]  = '{chain: 2'd0, dat: 4'b0000, drv: 4'b0000, exp: 1'b1};
    vecs[1]  = '{chain: 2'd0, dat: 4'b0000, drv: 4'b0000, exp: 1'b0};
    vecs[2]  = '{chain: 2'd0, dat: 4'b0000, drv: 4'b0000, exp: 1'b0};
    vecs[3]  = '{chain: 2'd0, dat: 4'b0000, drv: 4'b0000, exp: 1'b0};
    vecs[4]  = '{chain: 2'd0, dat: 4'b0000, drv: 4'b0000, exp: 1'b0};
    vecs[5]  = '{chain: 2'd0, dat: 4'b0000, drv: 4'b0000, exp: 1'b1};
    vecs[6]  = '{chain: 2'd0, dat: 4'b0000, drv: 4'b0000, exp: 1'b1};
    vecs[7]  = '{chain: 2'd0, dat: 4'b0000, drv: 4'b0000, exp: 1'b1};
    vecs[8]  = '{chain: 2'd0, dat: 4'b1010, drv: 4'b1111, exp: 1'b0};
    vecs[9]  = '{chain: 2'd1, dat: 4'b1010, drv: 4'b1111, exp: 1'b1};
    vecs[10] = '{chain: 2'd2, dat: 4'b1010, drv: 4'b1111, exp: 1'b0};
    vecs[11] = '{chain: 2'd3, dat: 4'b1010, drv: 4'b1111, exp: 1'b1};
    vecs[12] = '{chain: 2'd1, dat: 4'b1111, drv: 4'b1101, exp: 1'b0};
    vecs[13] = '{chain: 2'd3, dat: 4'b0000, drv: 4'b0111, exp: 1'b1};

    repeat (3) tick();
    check("rst_tck",       {31'd0, jtag_TCK},   32'd0);
    check("rst_tms",       {31'd0, jtag_TMS},   32'd1);
    check("rst_tdi",       {31'd0, jtag_TDI},   32'd0);
    check("rst_trstn",     {31'd0, jtag_TRSTn}, 32'd1);
    check("rst_exit",      exit,                32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid},  32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready},  32'd0);

    reset = 1'b0;
    tick();
    check("ready_gated_by_enable", {31'd0, cmd_ready}, 32'd0);
    enable    = 1'b1;
    init_done = 1'b1;
    #1;
    check("ready_after_enable", {31'd0, cmd_ready}, 32'd1);

    for (int k = 0; k < 14; k++) begin
`ifdef SIM_JTAG_SEQUENCER_TDO_CHECK_EN
      if (vecs[k].drv[vecs[k].chain] == 1'b0) continue;
`endif
      send(OP_CLOCK, 1'b0, 1'b1, 1'b1, vecs[k].chain, 32'd0, vecs[k].dat, vecs[k].drv);
      get_rsp($sformatf("vec%0d_tdo", k), vecs[k].exp);
    end

    // CLOCK waveform with TCK_DIV=2: low 2, high 2, next fall 5 cycles after the last.
    send(OP_CLOCK, 1'b1, 1'b0, 1'b1, 2'd0, 32'd0, 4'b0001, 4'b0001);
    check("clk_lo0_tck", {31'd0, jtag_TCK},  32'd0);
    check("clk_tms",     {31'd0, jtag_TMS},  32'd1);
    check("clk_tdi",     {31'd0, jtag_TDI},  32'd0);
    check("clk_busy",    {31'd0, cmd_ready}, 32'd0);
    tick();
    check("clk_lo1_tck", {31'd0, jtag_TCK},  32'd0);
    tick();
    check("clk_hi0_tck", {31'd0, jtag_TCK},  32'd1);
    check("clk_hi0_rv",  {31'd0, rsp_valid}, 32'd0);
    tick();
    check("clk_hi1_tck", {31'd0, jtag_TCK},  32'd1);
    check("clk_hi1_rv",  {31'd0, rsp_valid}, 32'd1);
    check("clk_hi1_tdo", {31'd0, rsp_tdo},   32'd1);
    tick();
    check("clk_idle_ready", {31'd0, cmd_ready}, 32'd1);
    check("clk_idle_tck",   {31'd0, jtag_TCK},  32'd1);
    send(OP_CLOCK, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 4'b0001, 4'b0001);
    check("clk_period_fall", {31'd0, jtag_TCK}, 32'd0);
    repeat (4) tick();
    get_rsp("clk_pop", 1'b1);

    // Backpressure: two captures fill the FIFO and the third must wait for a pop.
    send(OP_CLOCK, 1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 4'b0001, 4'b0001);
    send(OP_CLOCK, 1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 4'b0000, 4'b0001);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cmd_ready) seen = 1'b1;
    end
    check("full_stall",   {31'd0, seen},      32'd0);
    check("full_rv",      {31'd0, rsp_valid}, 32'd1);
    check("full_head",    {31'd0, rsp_tdo},   32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("pop_ready",    {31'd0, cmd_ready}, 32'd1);
    check("pop_next_tdo", {31'd0, rsp_tdo},   32'd0);
    send(OP_CLOCK, 1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 4'b0001, 4'b0001);
    get_rsp("fifo_second", 1'b0);
    get_rsp("fifo_third",  1'b1);

    send(OP_TRST, 1'b0, 1'b0, 1'b0, 2'd0, 32'd5, 4'd0, 4'd0);
    check("trst_tck_held", {31'd0, jtag_TCK}, 32'd1);
    n = 0;
    while (!jtag_TRSTn && n < 50) begin
      n++;
      tick();
    end
    check("trst5_len", n, 32'd5);
    send(OP_TRST, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0, 4'd0);
    n = 0;
    while (!jtag_TRSTn && n < 50) begin
      n++;
      tick();
    end
    check("trst0_len", n, 32'd1);

    send(OP_WAIT, 1'b0, 1'b0, 1'b0, 2'd0, 32'd3, 4'd0, 4'd0);
    n = 0;
    while (!cmd_ready && n < 50) begin
      n++;
      tick();
    end
    check("wait3_len", n, 32'd3);
    send(OP_WAIT, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0, 4'd0);
    check("wait0_ready", {31'd0, cmd_ready}, 32'd1);

    // EXIT with a response still queued: code latched, FIFO still drains.
    send(OP_CLOCK, 1'b0, 1'b0, 1'b1, 2'd2, 32'd0, 4'b0100, 4'b0100);
    send(OP_EXIT, 1'b0, 1'b0, 1'b0, 2'd0, 32'd7, 4'd0, 4'd0);
    check("exit_code", exit, 32'hF);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (cmd_ready) seen = 1'b1;
      tick();
    end
    check("exit_no_ready", {31'd0, seen}, 32'd0);
    get_rsp("exit_drain", 1'b1);
    check("exit_sticky", exit, 32'hF);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    send(OP_CLOCK, 1'b0, 1'b1, 1'b1, 2'd0, 32'd0, 4'b0001, 4'b0001);
    tick();
    tick();
    check("mid_hi_tck", {31'd0, jtag_TCK}, 32'd1);
    reset = 1'b1;
    tick();
    check("abort_tck",   {31'd0, jtag_TCK},   32'd0);
    check("abort_tms",   {31'd0, jtag_TMS},   32'd1);
    check("abort_tdi",   {31'd0, jtag_TDI},   32'd0);
    check("abort_trstn", {31'd0, jtag_TRSTn}, 32'd1);
    check("abort_exit",  exit,                32'd0);
    check("abort_rv",    {31'd0, rsp_valid},  32'd0);
    check("abort_ready", {31'd0, cmd_ready},  32'd0);
    reset = 1'b0;
    repeat (3) tick();
    check("after_abort_rv",    {31'd0, rsp_valid}, 32'd0);
    check("after_abort_ready", {31'd0, cmd_ready}, 32'd1);

`ifdef SIM_JTAG_SEQUENCER_TDO_CHECK_EN
    send(OP_CLOCK, 1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 4'd0, 4'd0);
    repeat (8) tick();
    check("tdo_check_exit",  exit,                32'h3);
    check("tdo_check_ready", {31'd0, cmd_ready},  32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sim_jtag_sequencer.md
Name: sim_jtag_sequencer

Overview:
- Clocked, parametrised JTAG bit-bang driver for simulation harnesses.
- Consumes a valid/ready command stream: single TCK cycle, TRSTn pulse, idle wait, or exit. Returns captured TDO bits through a buffered valid/ready response stream.
- Generalises the free-running tick driver:
  - programmable TCK divider
  - N selectable TDO chains
  - response buffering with backpressure
  - deterministic substitution of undriven TDO
- Sits between a host-side command source (DPI shim or testbench) and the DUT debug TAP.

Parameters:
- TCK_DIV, 2, clock cycles per TCK half-period (>=1)
- N_CHAINS, 1, number of TDO inputs selectable per command (>=1)
- RSP_DEPTH, 4, response FIFO depth (>=1)
- LFSR_SEED, 16'hACE1, reset value of undriven-TDO substitution LFSR (nonzero)

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- enable  in  1  command acceptance qualifier
- init_done  in  1  command acceptance qualifier
- cmd_valid  in  1  command handshake
- cmd_ready  out  1  command handshake
- cmd_op  in  2  0=CLOCK, 1=TRST, 2=WAIT, 3=EXIT
- cmd_tms  in  1  TMS value for CLOCK
- cmd_tdi  in  1  TDI value for CLOCK
- cmd_capture  in  1  CLOCK: push sampled TDO to response FIFO
- cmd_chain  in  max(1,$clog2(N_CHAINS))  TDO chain select
- cmd_data  in  32  TRST/WAIT cycle count; EXIT code
- rsp_valid  out  1  response handshake
- rsp_ready  in  1  response handshake
- rsp_tdo  out  1  captured TDO bit
- jtag_TCK  out  1  JTAG clock
- jtag_TMS  out  1  JTAG mode select
- jtag_TDI  out  1  JTAG data in
- jtag_TRSTn  out  1  JTAG reset, active-low
- jtag_TDO_data  in  N_CHAINS  per-chain TDO
- jtag_TDO_driven  in  N_CHAINS  per-chain TDO output-enable
- exit  out  32  0 while running; (code<<1)|1 after EXIT

Behaviour:
- Reset values (all outputs registered):
  - TCK=0, TMS=1, TDI=0, TRSTn=1, exit=0, rsp_valid=0, cmd_ready=0
  - FIFO empty, LFSR=LFSR_SEED, state IDLE
  - Reset asserted mid-command aborts it immediately; no partial response is pushed.
- cmd_ready = (state==IDLE) & enable & init_done & (fifo_count<RSP_DEPTH).
  - Independent of cmd_valid and cmd_op.
  - Accept on cmd_valid & cmd_ready.
  - A command in flight completes even if enable/init_done drop.
- States: IDLE, TCK_LO, TCK_HI, TRST, WAIT, DONE.
- CLOCK:
  - Accept → TCK_LO. On the next cycle TMS/TDI update, TCK=0, held TCK_DIV cycles.
  - Then TCK_HI: TCK=1 for TCK_DIV cycles.
  - TDO sampled on the cycle TCK rises, into a register.
  - If cmd_capture=1, the sample is pushed to the FIFO on that same edge.
  - Then IDLE; TCK returns to 0 only when the next CLOCK enters TCK_LO (TCK stays 1 between commands).
  - Back-to-back CLOCK period = 2*TCK_DIV+1 cycles.
- TDO selection:
  - sampled bit = jtag_TDO_driven[chain] ? jtag_TDO_data[chain] : lfsr[0].
  - cmd_chain>=N_CHAINS selects lfsr[0].
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle TDO is sampled.
- TRST: TRSTn=0 for max(cmd_data,1) cycles; TCK/TMS/TDI held; then TRSTn=1, IDLE.
- WAIT: outputs held for cmd_data cycles (0 → back in IDLE next cycle).
- EXIT: exit <= {cmd_data[30:0],1'b1}; state DONE; cmd_ready=0 until reset. Response FIFO still drains.
- FIFO:
  - Response visible 1 cycle after push (rsp_valid registered-out).
  - Simultaneous push and pop when full is legal. Push only occurs when space was reserved at accept, so overflow is impossible.
  - Pop only on rsp_valid & rsp_ready.
  - Order preserved, pointer wrap-around at RSP_DEPTH.

Optional Feature:
- Macro SIM_JTAG_SEQUENCER_TDO_CHECK_EN.
- Defined:
  - Sampling an undriven TDO with cmd_capture=1 issues $error.
  - A sticky error sets exit <= 32'h3 (code 1) at that edge and enters DONE after the current CLOCK completes.
- Undefined: LFSR substitution is silent; no check logic is compiled.

Test Plan:
- TCK_DIV=2, CLOCK tms=1 tdi=0 capture=1, TDO driven 1 → TCK low 2 cycles, high 2 cycles; rsp_tdo=1 one cycle after rising edge; period 5 cycles.
- N_CHAINS=4, 4 captures chain=0..3 with TDO_data=4'b1010 all driven → responses 0,1,0,1 in order.
- RSP_DEPTH=2, rsp_ready=0, 3 capture commands → third stalls (cmd_ready=0) until one pop, then proceeds; no loss.
- TRST cmd_data=5 → TRSTn low exactly 5 cycles; cmd_data=0 → low 1 cycle.
- TDO undriven, seed 16'hACE1, 8 captures → bits match the reference LFSR sequence; with SIM_JTAG_SEQUENCER_TDO_CHECK_EN, exit=32'h3.
- EXIT cmd_data=7 → exit=32'hF, cmd_ready stays 0; reset mid-TCK_HI → outputs return to reset values next cycle.
